// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared definitions for the keypad emulator: FSM state
//               encoding, keycode field positions, default timing values
//               and the bounce LFSR seed/taps.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Emulator FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } kp_state_t;

  // Keycode layout: {row[1:0], col[2:0]}
  localparam int ROW_MSB = 4;
  localparam int ROW_LSB = 3;
  localparam int COL_MSB = 2;
  localparam int COL_LSB = 0;

  // 10 ms all-released interval and 0.5 ms bounce window at 5 MHz
  localparam int DEF_GAP_CYCLES    = 50000;
  localparam int DEF_BOUNCE_CYCLES = 2500;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/kp_bounce_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : kp_bounce_lfsr
// Description : 16-bit Fibonacci LFSR used as the contact-bounce noise
//               source. Shifts left; the new feedback bit enters at bit 0,
//               which is the bit presented to the contact gate.
// Ports       : clock       - system clock
//               resetn      - asynchronous reset, active low (loads seed)
//               en          - advance the register this cycle
//               contact_bit - bit 0 of the register
// Revision    : 1.0 - initial release
// ============================================================================
module kp_bounce_lfsr
  import keypad_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic en,
  output logic contact_bit
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign contact_bit = lfsr[0];

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator
// Description : Responder side of the 4x6 keypad row/column scan. Accepts a
//               key-press request (keycode + hold time), then for the hold
//               time mirrors the captured row strobe onto the captured column
//               line (registered, 1-cycle latency), followed by a mandatory
//               all-released gap. Build option KPEMU_BOUNCE_EN adds LFSR
//               driven contact bounce at the start of press and of gap.
// Ports       : clock, resetn          - clock, async active-low reset
//               req_valid/req_ready    - request handshake
//               req_code               - {row[1:0], col[2:0]}
//               req_hold               - press duration in cycles (0 => 1)
//               kprow                  - row strobes from scanner, active low
//               kpcol                  - column lines, active low, idle '1
//               busy                   - press or gap in progress
//               done                   - 1-cycle pulse at end of gap
//               err                    - 1-cycle pulse on invalid keycode
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 6,
  parameter int CNT_W         = 24,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int BOUNCE_CYCLES = DEF_BOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [4:0]       req_code,
  input  logic [CNT_W-1:0] req_hold,
  output logic             req_ready,
  input  logic [ROWS-1:0]  kprow,
  output logic [COLS-1:0]  kpcol,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if (GAP_CYCLES < 1 || BOUNCE_CYCLES < 0) begin : g_bad_param
    $error("keypad_emulator: GAP_CYCLES must be >= 1 and BOUNCE_CYCLES >= 0");
  end

  kp_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [COLS-1:0]  kpcol_q, kpcol_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [1:0]       req_row;
  logic [2:0]       req_col;
  logic             row_ok, col_ok, code_ok;
  logic [CNT_W-1:0] hold_eff;
  logic             row_line;
  logic             contact_press, contact_gap;

  assign req_row = req_code[ROW_MSB:ROW_LSB];
  assign req_col = req_code[COL_MSB:COL_LSB];

  // A 2-bit row field can never exceed a 4-row matrix, and a 3-bit column
  // field can never exceed an 8-column one; only compare when it can fail.
  if (ROWS >= 4) begin : g_row_full
    assign row_ok = 1'b1;
  end else begin : g_row_lim
    assign row_ok = (int'(req_row) < ROWS);
  end

  if (COLS >= 8) begin : g_col_full
    assign col_ok = 1'b1;
  end else begin : g_col_lim
    assign col_ok = (int'(req_col) < COLS);
  end

  assign code_ok = row_ok && col_ok;

  // Level of the captured row strobe (only this row matters, even if the
  // scanner drives several rows low together).
  always_comb begin
    row_line = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == 2'(r)) row_line = kprow[r];
    end
  end

`ifdef KPEMU_BOUNCE_EN
  logic             bounce_bit;
  logic [CNT_W-1:0] bnc_q, bnc_d;

  kp_bounce_lfsr u_lfsr (
    .clock       (clock),
    .resetn      (resetn),
    .en          (1'b1),
    .contact_bit (bounce_bit)
  );

  // Inside the bounce window the contact only closes when the LFSR bit is 1.
  // During press that chops the row strobe; during gap it gives release
  // chatter that still follows the row strobe while momentarily closed.
  assign contact_press = (bnc_q != '0) ? (row_line | ~bounce_bit) : row_line;
  assign contact_gap   = (bnc_q != '0) ? (row_line | ~bounce_bit) : 1'b1;
`else
  assign contact_press = row_line;
  assign contact_gap   = 1'b1;
`endif

  always_comb begin
    hold_eff = (req_hold == '0) ? CNT_W'(1) : req_hold;
`ifdef KPEMU_BOUNCE_EN
    // Press must outlast the bounce window so the key settles closed.
    if (hold_eff < CNT_W'(BOUNCE_CYCLES + 1)) hold_eff = CNT_W'(BOUNCE_CYCLES + 1);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    kpcol_d = '1;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef KPEMU_BOUNCE_EN
    bnc_d   = (bnc_q != '0) ? (bnc_q - CNT_W'(1)) : bnc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (code_ok) begin
            state_d = ST_PRESS;
            cnt_d   = hold_eff;
            row_d   = req_row;
            col_d   = req_col;
`ifdef KPEMU_BOUNCE_EN
            bnc_d   = CNT_W'(BOUNCE_CYCLES);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        for (int c = 0; c < COLS; c++) begin
          if (col_q == 3'(c)) kpcol_d[c] = contact_press;
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES);
`ifdef KPEMU_BOUNCE_EN
          bnc_d   = CNT_W'(BOUNCE_CYCLES);
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        for (int c = 0; c < COLS; c++) begin
          if (col_q == 3'(c)) kpcol_d[c] = contact_gap;
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      kpcol_q <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kpcol_q <= kpcol_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef KPEMU_BOUNCE_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bnc_q <= '0;
    end else begin
      bnc_q <= bnc_d;
    end
  end
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign kpcol     = kpcol_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_emulator
// Description : Self-checking bench for keypad_emulator (default build).
//               A timeline model (accept cycle, hold, gap length) predicts
//               every output each cycle while kprow is driven with a
//               scanner rotation mixed with random multi-row patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

  localparam int ROWS  = 4;
  localparam int COLS  = 6;
  localparam int CNT_W = 24;
  localparam int G     = 400;

  logic             clock;
  logic             resetn;
  logic             req_valid;
  logic [4:0]       req_code;
  logic [CNT_W-1:0] req_hold;
  logic             req_ready;
  logic [ROWS-1:0]  kprow;
  logic [COLS-1:0]  kpcol;
  logic             busy;
  logic             done;
  logic             err;

  keypad_emulator #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .CNT_W         (CNT_W),
    .GAP_CYCLES    (G),
    .BOUNCE_CYCLES (100)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_hold  (req_hold),
    .req_ready (req_ready),
    .kprow     (kprow),
    .kpcol     (kpcol),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #10 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Timeline model: a valid press accepted at edge acc_t occupies cycles
  // acc_t .. acc_t+h_m+G-1, done shows in cycle acc_t+h_m+G.
  int acc_t = -1;
  int h_m   = 0;
  int err_t = -1;
  int row_m = 0;
  int col_m = 0;
  logic [3:0] sampled;
  int scan_idx  = 0;
  int force_row = -1;

  function automatic bit busy_at(input int n);
    return (acc_t >= 0) && (n >= acc_t) && (n < acc_t + h_m + G);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic [5:0] exp_col;
    int rel;
    int h;
    @(posedge clock);
    cyc++;
    sampled = kprow;
    if (!resetn) begin
      acc_t = -1;
      err_t = -1;
    end else if (req_valid && !busy_at(cyc - 1)) begin
      if (int'(req_code[2:0]) < COLS && int'(req_code[4:3]) < ROWS) begin
        acc_t = cyc;
        h     = int'(req_hold);
        h_m   = (h == 0) ? 1 : h;
        row_m = int'(req_code[4:3]);
        col_m = int'(req_code[2:0]);
      end else begin
        err_t = cyc;
      end
    end
    @(negedge clock);
    rel     = cyc - acc_t;
    exp_col = 6'h3F;
    if (acc_t >= 0 && rel >= 1 && rel <= h_m) exp_col[col_m] = sampled[row_m];
    check("kpcol", 32'(kpcol), 32'(exp_col));
    check("req_ready", 32'(req_ready), 32'(!busy_at(cyc)));
    check("busy", 32'(busy), 32'(busy_at(cyc)));
    check("done", 32'(done), 32'((acc_t >= 0) && (rel == h_m + G)));
    check("err", 32'(err), 32'(err_t == cyc));
    if (force_row >= 0) kprow = ~(4'b0001 << force_row);
    else if ($urandom_range(7) == 0) kprow = 4'($urandom);
    else begin
      scan_idx = (scan_idx + 1) % 4;
      kprow    = ~(4'b0001 << scan_idx);
    end
  endtask

  task automatic request(input logic [4:0] code, input logic [CNT_W-1:0] hold);
    req_valid = 1'b1;
    req_code  = code;
    req_hold  = hold;
    cycle();
    req_valid = 1'b0;
    req_code  = 5'($urandom);
    req_hold  = CNT_W'($urandom);
  endtask

  task automatic wait_ready(input int limit, input bit noise,
                            output int dones, output int busy_cycles, output int errs);
    int n;
    n = 0; dones = 0; busy_cycles = 0; errs = 0;
    do begin
      if (noise) begin
        req_valid = 1'($urandom);
        req_code  = 5'($urandom);
        req_hold  = CNT_W'($urandom_range(0, 30));
      end
      cycle();
      n++;
      if (done) dones++;
      if (busy) busy_cycles++;
      if (err)  errs++;
    end while (!req_ready && n < limit);
    req_valid = 1'b0;
    check("wait_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int d, b, e, cnt;
    logic err_now;
    clock = 1'b0; resetn = 1'b0; req_valid = 1'b0;
    req_code = '0; req_hold = '0; kprow = '1;

    // Reset state, then idle scanning with no request
    repeat (4) cycle();
    resetn = 1'b1;
    repeat (24) cycle();

    // Row 1 / col 2, hold 1000: press then gap, one done
    request(5'b01_010, CNT_W'(1000));
    wait_ready(3000, 1'b0, d, b, e);
    check("press_done_count", 32'(d), 32'd1);
    check("press_busy_len", 32'(b + 1), 32'(1000 + G));
    repeat (5) cycle();

    // Invalid column 6: err one cycle after acceptance, stays idle
    request(5'b11_110, CNT_W'(5));
    err_now = err;
    check("err_pulse", 32'(err_now), 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (err || done || busy) cnt++;
    end
    check("err_quiet", 32'(cnt), 32'd0);
    request(5'b00_111, CNT_W'(9));
    err_now = err;
    check("err_pulse_col7", 32'(err_now), 32'd1);
    repeat (3) cycle();

    // Reset 300 cycles into a 1000-cycle press
    request(5'b10_001, CNT_W'(1000));
    repeat (290) cycle();
    force_row = 2;
    repeat (10) cycle();
    check("kpcol_pre_reset", 32'(kpcol[1]), 32'd0);
    #5 resetn = 1'b0;
    #1;
    acc_t = -1; err_t = -1;
    check("kpcol_async_reset", 32'(kpcol), 32'h3F);
    check("busy_async_reset", 32'(busy), 32'd0);
    check("ready_async_reset", 32'(req_ready), 32'd1);
    force_row = -1;
    repeat (3) cycle();
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (done) cnt++;
    end
    check("no_done_after_reset", 32'(cnt), 32'd0);

    // Hold boundaries: 0 behaves as 1, and 1
    request(5'b00_000, CNT_W'(0));
    wait_ready(3000, 1'b0, d, b, e);
    check("hold0_busy_len", 32'(b + 1), 32'(1 + G));
    request(5'b11_101, CNT_W'(1));
    wait_ready(3000, 1'b0, d, b, e);
    check("hold1_busy_len", 32'(b + 1), 32'(1 + G));
    check("hold1_done", 32'(d), 32'd1);

    // Randomized back-to-back requests with noisy inputs while busy
    for (int k = 0; k < 12; k++) begin
      request(5'($urandom), CNT_W'($urandom_range(0, 40)));
      wait_ready(3000, 1'b1, d, b, e);
    end
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Responder end of the keypad row/column scan interface: behaves as the physical 4x6 keypad for the keypad scanner.
- Accepts key-press requests as a keycode plus a hold time, watches the scanner's active-low kprow strobes and pulls the matching kpcol line low.
- Used in the 5 MHz clock domain for hardware-in-loop replay and for self-checking benches of the scanner and calculator path.

Parameters:
- ROWS, 4, number of row lines driven by the scanner.
- COLS, 6, number of column lines returned to the scanner.
- CNT_W, 24, width of the hold and gap counters.
- GAP_CYCLES, 50000, mandatory all-released interval after each press (10 ms at 5 MHz).
- BOUNCE_CYCLES, 2500, bounce window length; used only with KPEMU_BOUNCE_EN.

Ports:
- clock  in  1  5 MHz system clock.
- resetn  in  1  asynchronous reset, active low.
- req_valid  in  1  key-press request is valid.
- req_code  in  5  keycode to press: {row[1:0], col[2:0]}.
- req_hold  in  CNT_W  press duration in clock cycles.
- req_ready  out  1  emulator can accept a request.
- kprow  in  ROWS  row strobes from the scanner, active low.
- kpcol  out  COLS  column lines to the scanner, active low, idle all ones.
- busy  out  1  press or gap in progress.
- done  out  1  one-cycle pulse when the gap after a press ends.
- err  out  1  one-cycle pulse when a request has an invalid code.

Behaviour:
- Reset values: kpcol all ones, req_ready 1, busy 0, done 0, err 0, FSM IDLE, counters 0.
- Handshake: a request is accepted on a rising clock edge where req_valid and req_ready are both 1.
  - req_ready is 1 only in IDLE.
  - req_code and req_hold are captured at acceptance; later input changes are ignored.
- Code validity: code is valid when row = req_code[4:3] < ROWS and col = req_code[2:0] < COLS.
  - Invalid code: err pulses the cycle after acceptance, FSM stays IDLE, kpcol stays all ones.
- req_hold of 0 is treated as 1.
- FSM states and transitions:
  - IDLE -> PRESS on acceptance of a valid code; load the hold counter with req_hold.
  - PRESS: hold counter decrements every cycle; at 1 go to GAP and load GAP_CYCLES.
  - GAP: kpcol forced all ones; counter decrements; at 1 pulse done and return to IDLE.
- Column drive:
  - kpcol is registered, giving 1-cycle latency from kprow.
  - In PRESS, next kpcol[col] = kprow[row]; all other columns are 1.
  - In every other state kpcol = all ones.
  - Multiple rows strobed low at once: the column follows the captured row line only.
- busy = 1 in PRESS and GAP.
- done and err never assert in the same cycle.
- Reset mid-press: the key releases immediately (kpcol all ones, asynchronously) and the request is lost; done does not pulse.

Optional Feature:
- KPEMU_BOUNCE_EN defined:
  - For the first BOUNCE_CYCLES of PRESS and the first BOUNCE_CYCLES of GAP, the contact is gated by bit 0 of a 16-bit Fibonacci LFSR.
  - LFSR: taps 16,14,13,11; seed 16'hACE1 at reset; advances every cycle.
  - When the bit is 0 the contact reads as open (kpcol all ones).
  - PRESS must be at least BOUNCE_CYCLES long: req_hold is internally raised to BOUNCE_CYCLES+1 if smaller.
- KPEMU_BOUNCE_EN not defined: the contact is clean, with no LFSR and no extra logic.

Decomposition:
- Package keypad_pkg holds:
  - FSM state encoding (IDLE, PRESS, GAP);
  - keycode field positions (ROW_MSB=4, ROW_LSB=3, COL_MSB=2, COL_LSB=0);
  - default GAP_CYCLES and BOUNCE_CYCLES;
  - LFSR seed and taps.
- One sub-module: kp_bounce_lfsr, the 16-bit LFSR with enable, instantiated only under KPEMU_BOUNCE_EN.

Test Plan:
- Reset, then scanner model strobes kprow 1110, 1101, 1011, 0111 repeatedly -> kpcol stays 6'b111111; req_ready=1; busy=0.
- Request code 5'b01_010 (row 1, col 2), hold 1000 -> kpcol=6'b111011 exactly 1 cycle after each cycle with kprow=1101, otherwise 111111.
  - After 1000 PRESS cycles, GAP lasts 50000 cycles, then done pulses once and req_ready returns to 1.
- Request code 5'b11_110 (col 6, invalid) -> err pulses one cycle after acceptance, kpcol never leaves 111111, done never pulses.
- Assert resetn low 300 cycles into a 1000-cycle press -> kpcol=111111 immediately, busy=0, no done pulse.
- End-to-end with the real scanner and calculator: press codes for 1, 2, +, 3, = with hold 25000 each -> exactly five newkey pulses with matching keycodes, calcOut=16'h0015.
- With KPEMU_BOUNCE_EN: hold 20000 on code 5'b00_000 -> kpcol[0] toggles during the first 2500 cycles and is stable low on row-0 strobes afterwards; the scanner reports exactly one newkey.
